// File: rtl/sum_ascii_tx_ctrl.sv
// sum_ascii_tx_ctrl: sends a captured 5-bit sum as two ASCII decimal digits
// (optionally followed by CR LF) through a byte-wide UART transmitter,
// using a send-strobe / busy handshake. This is a Moore FSM.
module sum_ascii_tx_ctrl #(
    parameter int SEND_CRLF = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [4:0] sum,
    input  logic       uart_tx_busy,
    output logic       uart_tx_en,
    output logic [7:0] uart_tx_data,
    output logic       busy,
    output logic       done
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ARM       = 3'd1;
    localparam logic [2:0] S_SEND      = 3'd2;
    localparam logic [2:0] S_WAIT_ACK  = 3'd3;
    localparam logic [2:0] S_WAIT_FREE = 3'd4;

    // Index of the final byte of a message: CR LF adds two bytes.
    localparam logic [1:0] LAST_IDX = (SEND_CRLF != 0) ? 2'd3 : 2'd1;

    logic [2:0] r_state;
    logic [1:0] r_idx;
    logic [4:0] r_sum;
    logic       r_done;

    logic [1:0] w_tens;
    logic [3:0] w_ones;
    logic [7:0] w_byte;
    logic       w_in_xfer;

    // Split the captured sum (0..31) into tens and ones digits.
    always_comb begin
        w_tens = 2'd0;
        w_ones = 4'(r_sum);
        if (r_sum >= 5'd30) begin
            w_tens = 2'd3;
            w_ones = 4'(r_sum - 5'd30);
        end else if (r_sum >= 5'd20) begin
            w_tens = 2'd2;
            w_ones = 4'(r_sum - 5'd20);
        end else if (r_sum >= 5'd10) begin
            w_tens = 2'd1;
            w_ones = 4'(r_sum - 5'd10);
        end
    end

    // Select the message byte addressed by the byte index.
    always_comb begin
        w_byte = 8'h00;
        case (r_idx)
            2'd0:    w_byte = {6'b001100, w_tens};
            2'd1:    w_byte = {4'h3, w_ones};
            2'd2:    w_byte = 8'h0D;
            default: w_byte = 8'h0A;
        endcase
    end

    // A byte is "in transfer" from its strobe until the UART releases busy;
    // the data bus holds that byte for the whole window and is 0 otherwise.
    assign w_in_xfer = (r_state == S_SEND) || (r_state == S_WAIT_ACK) ||
                       (r_state == S_WAIT_FREE);

    assign uart_tx_en   = (r_state == S_SEND);
    assign uart_tx_data = w_in_xfer ? w_byte : 8'h00;
    assign busy         = (r_state != S_IDLE);
    assign done         = r_done;

    // Message sequencer: capture, wait for a free UART, strobe each byte,
    // then wait for the UART to take it (busy high) and finish it (busy low).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_idx   <= 2'd0;
            r_sum   <= 5'd0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_sum   <= sum;
                        r_idx   <= 2'd0;
                        r_state <= S_ARM;
                    end
                end
                S_ARM: begin
                    // A transfer owned by someone else may still be running.
                    if (!uart_tx_busy) r_state <= S_SEND;
                end
                S_SEND: begin
                    r_state <= S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    if (uart_tx_busy) r_state <= S_WAIT_FREE;
                end
                S_WAIT_FREE: begin
                    if (!uart_tx_busy) begin
                        if (r_idx == LAST_IDX) begin
                            r_state <= S_IDLE;
                            r_done  <= 1'b1;
                        end else begin
                            r_idx   <= r_idx + 2'd1;
                            r_state <= S_SEND;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sum_ascii_tx_ctrl.sv
// Bench for sum_ascii_tx_ctrl: one instance with CR LF, one without, sharing
// stimulus. Each has a UART model (busy rises one cycle after the strobe and
// lasts UART_LEN cycles) and a byte scoreboard fed when start is driven.
module tb_sum_ascii_tx_ctrl;

    localparam int UART_LEN = 10;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [4:0] sum;
    logic       ext_busy;

    logic       ubusy  [2];
    logic       en     [2];
    logic [7:0] data   [2];
    logic       busy_o [2];
    logic       done_o [2];

    int         ucnt     [2];
    logic [7:0] last_b   [2];
    int         en_cnt   [2];
    int         done_cnt [2];
    int         exp_done [2];

    logic [7:0] q0[$];
    logic [7:0] q1[$];

    int n_chk;
    int n_err;

    sum_ascii_tx_ctrl #(.SEND_CRLF(0)) u_dut0 (
        .clk(clk), .reset_n(rst_n), .start(start), .sum(sum),
        .uart_tx_busy(ubusy[0]), .uart_tx_en(en[0]), .uart_tx_data(data[0]),
        .busy(busy_o[0]), .done(done_o[0])
    );

    sum_ascii_tx_ctrl #(.SEND_CRLF(1)) u_dut1 (
        .clk(clk), .reset_n(rst_n), .start(start), .sum(sum),
        .uart_tx_busy(ubusy[1]), .uart_tx_en(en[1]), .uart_tx_data(data[1]),
        .busy(busy_o[1]), .done(done_o[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Expected bytes of one message for instance d (d=1 carries CR LF).
    task automatic push_msg(input int d, input int s);
        logic [7:0] t;
        logic [7:0] o;
        t = 8'(8'h30 + s / 10);
        o = 8'(8'h30 + s % 10);
        exp_done[d]++;
        if (d == 0) begin
            q0.push_back(t); q0.push_back(o);
        end else begin
            q1.push_back(t); q1.push_back(o); q1.push_back(8'h0D); q1.push_back(8'h0A);
        end
    endtask

    // Per-instance monitor and UART model, evaluated on the falling edge.
    task automatic mon(input int d);
        logic [7:0] e;
        int         qs;
        if (!rst_n) begin
            ucnt[d]  = 0;
            ubusy[d] = ext_busy;
            return;
        end
        if (ucnt[d] != 0) chk("hold_data", data[d], last_b[d]);
        if (en[d]) begin
            en_cnt[d]++;
            last_b[d] = data[d];
            qs = (d == 0) ? q0.size() : q1.size();
            if (qs == 0) chk("extra_en", en[d], 0);
            else begin
                e = (d == 0) ? q0.pop_front() : q1.pop_front();
                chk(d == 0 ? "byte0" : "byte1", data[d], e);
            end
        end
        if (done_o[d]) begin
            done_cnt[d]++;
            chk("done_busy", busy_o[d], 0);
        end
        if (en[d]) ucnt[d] = UART_LEN + 1;
        else if (ucnt[d] > 0) ucnt[d]--;
        ubusy[d] = ext_busy || (ucnt[d] != 0 && ucnt[d] <= UART_LEN);
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    task automatic wait_done(input int t0, input int t1, input string tag);
        bit ok;
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done_cnt[0] >= t0 && done_cnt[1] >= t1) begin
                ok = 1;
                break;
            end
        end
        chk(tag, ok, 1);
    endtask

    task automatic pulse_start(input logic [4:0] s);
        @(negedge clk);
        start = 1'b1;
        sum   = s;
        push_msg(0, s);
        push_msg(1, s);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic chk_reset_outs(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk({tag, "_en"},   en[d],     0);
            chk({tag, "_data"}, data[d],   0);
            chk({tag, "_busy"}, busy_o[d], 0);
            chk({tag, "_done"}, done_o[d], 0);
        end
    endtask

    initial begin
        int e1, e0, d1, d0, k1;
        bit pend [2];
        bit ok;
        n_chk = 0; n_err = 0;
        start = 0; sum = 0; ext_busy = 0;
        for (int d = 0; d < 2; d++) begin
            ucnt[d] = 0; last_b[d] = 0; en_cnt[d] = 0; done_cnt[d] = 0;
            exp_done[d] = 0; ubusy[d] = 0; pend[d] = 0;
        end
        rst_n = 1;
        #1 rst_n = 0;
        #1 chk_reset_outs("rst");
        repeat (3) @(negedge clk);
        rst_n = 1;
        // First cycle after release: nothing may be strobed.
        @(negedge clk);
        chk("rel_en0", en[0], 0);
        chk("rel_en1", en[1], 0);

        // sum=23: latency start -> strobe is two cycles.
        e1 = en_cnt[1]; e0 = en_cnt[0];
        @(negedge clk);
        start = 1; sum = 5'd23;
        push_msg(0, 23); push_msg(1, 23);
        @(negedge clk);
        start = 0;
        chk("lat_busy", busy_o[1], 1);
        chk("lat_en_c1", en[1], 0);
        @(negedge clk);
        chk("lat_en_c2", en[1], 1);
        wait_done(1, 1, "tmo_23");
        chk("en_cnt_23_crlf", en_cnt[1] - e1, 4);
        chk("en_cnt_23_bare", en_cnt[0] - e0, 2);
        chk("done_23", done_cnt[1], 1);

        // Extremes of the input range.
        pulse_start(5'd0);
        wait_done(2, 2, "tmo_0");
        pulse_start(5'd31);
        wait_done(3, 3, "tmo_31");

        // Foreign transfer in progress: must wait in ARM.
        @(negedge clk);
        ext_busy = 1;
        pulse_start(5'd9);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("arm_en", en[1], 0);
            chk("arm_busy", busy_o[1], 1);
        end
        ext_busy = 0;
        wait_done(4, 4, "tmo_9");

        // Restart and sum change mid-message are ignored.
        e1 = en_cnt[1]; e0 = en_cnt[0];
        pulse_start(5'd17);
        repeat (15) @(negedge clk);
        start = 1; sum = 5'd5;
        @(negedge clk);
        start = 0;
        wait_done(5, 5, "tmo_17");
        repeat (40) @(negedge clk);
        chk("en_cnt_17_crlf", en_cnt[1] - e1, 4);
        chk("en_cnt_17_bare", en_cnt[0] - e0, 2);

        // Reset after the second byte has been strobed.
        e1 = en_cnt[1];
        pulse_start(5'd28);
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (en_cnt[1] - e1 >= 2) begin ok = 1; break; end
        end
        chk("tmo_2nd_byte", ok, 1);
        @(negedge clk);
        #3 rst_n = 0;
        #1 chk_reset_outs("abort");
        q0.delete(); q1.delete();
        exp_done[0]--; exp_done[1]--;
        e1 = en_cnt[1]; e0 = en_cnt[0]; d1 = done_cnt[1]; d0 = done_cnt[0];
        repeat (3) @(negedge clk);
        rst_n = 1;
        repeat (30) @(negedge clk);
        chk("abort_en1", en_cnt[1] - e1, 0);
        chk("abort_en0", en_cnt[0] - e0, 0);
        chk("abort_done1", done_cnt[1] - d1, 0);
        chk("abort_done0", done_cnt[0] - d0, 0);
        pulse_start(5'd28);
        wait_done(d0 + 1, d1 + 1, "tmo_28");

        // start held high: back-to-back messages, accepted in the done cycle.
        @(negedge clk);
        start = 1; sum = 5'd12;
        push_msg(0, 12); push_msg(1, 12);
        k1 = 0; ok = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (pend[d]) chk("b2b_accept", busy_o[d], 1);
                pend[d] = 0;
            end
            if (done_o[1]) k1++;
            if (k1 == 3) begin
                start = 0;
                ok = 1;
                break;
            end
            for (int d = 0; d < 2; d++)
                if (done_o[d]) begin
                    push_msg(d, 12);
                    pend[d] = 1;
                end
        end
        chk("tmo_b2b", ok, 1);
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!busy_o[0] && !busy_o[1]) begin ok = 1; break; end
        end
        chk("tmo_b2b_drain", ok, 1);
        repeat (5) @(negedge clk);

        chk("q0_left", q0.size(), 0);
        chk("q1_left", q1.size(), 0);
        chk("done_tot0", done_cnt[0], exp_done[0]);
        chk("done_tot1", done_cnt[1], exp_done[1]);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/sum_ascii_tx_ctrl.md
SUM_ASCII_TX_CTRL -- requirements
Module: sum_ascii_tx_ctrl

Interface
REQ-001 Parameter SEND_CRLF, default 1, 1 = append CR (0x0D) and LF (0x0A) after the two digit characters; 0 = digits only.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  request to transmit the current sum; level sampled each clk edge.
REQ-005 sum  input  5  unsigned adder result, 0..31.
REQ-006 uart_tx_busy  input  1  busy flag from the downstream UART transmitter.
REQ-007 uart_tx_en  output  1  one-cycle send strobe to the UART transmitter.
REQ-008 uart_tx_data  output  8  ASCII byte presented to the UART transmitter.
REQ-009 busy  output  1  high while a message is in progress (state != IDLE).
REQ-010 done  output  1  one-cycle pulse when the last byte of a message has completed.

Function
REQ-011 FSM states SHALL be IDLE, ARM, SEND, WAIT_ACK, WAIT_FREE; all outputs registered or decoded from state only (Moore).
REQ-012 IDLE: start=1 -> capture sum into internal register, clear byte index, go to ARM; start=0 -> stay.
REQ-013 ARM: uart_tx_busy=0 -> SEND; else stay (waits for a transfer not owned by this block to finish).
REQ-014 SEND: uart_tx_en=1 for exactly this one cycle, uart_tx_data = byte[index]; unconditionally go to WAIT_ACK.
REQ-015 WAIT_ACK: uart_tx_busy=1 -> WAIT_FREE; else stay; no timeout.
REQ-016 WAIT_FREE: uart_tx_busy=0 and index = last -> IDLE with done=1 in the following cycle; uart_tx_busy=0 and index != last -> index+1, go to SEND; else stay.
REQ-017 Message length N = 4 when SEND_CRLF=1, N = 2 when SEND_CRLF=0; last index = N-1.
REQ-018 Digits: tens = 3 if s>=30, 2 if s>=20, 1 if s>=10, else 0; ones = s - 10*tens; s = captured sum.
REQ-019 byte[0] = 0x30+tens, byte[1] = 0x30+ones, byte[2] = 0x0D, byte[3] = 0x0A; leading zero always sent (two digits fixed).
REQ-020 uart_tx_data SHALL hold byte[index] stable from SEND through WAIT_FREE of that byte.
REQ-021 Latency: start high in cycle 0 with uart_tx_busy low in cycle 1 -> uart_tx_en high in cycle 2.
REQ-022 sum changes after capture SHALL NOT affect the message in progress.
REQ-023 start while busy=1 SHALL be ignored (not queued).
REQ-024 done SHALL be high exactly one cycle, coincident with the first cycle back in IDLE; start high in that cycle SHALL be accepted.
REQ-025 busy SHALL go high the cycle after start is accepted and low in the same cycle done is high.

Reset
REQ-026 reset_n=0 SHALL immediately (asynchronously) force state IDLE, index 0, captured sum 0, uart_tx_en=0, uart_tx_data=0x00, busy=0, done=0.
REQ-027 Reset mid-message SHALL abort it with no further uart_tx_en and no done pulse; after reset_n rises, the block waits for a new start.
REQ-028 Reset deassertion SHALL take effect on the next clk edge; no uart_tx_en in the first cycle after release.

Verification
REQ-029 SEND_CRLF=1, sum=23, start pulse, UART model (busy 1 cycle after en, 10 cycles long) -> bytes 0x32,0x33,0x0D,0x0A, four uart_tx_en pulses, one done pulse.
REQ-030 sum=0 then sum=31 (two messages, SEND_CRLF=0) -> 0x30,0x30 then 0x33,0x31; done pulses after each.
REQ-031 uart_tx_busy held high for 20 cycles when start arrives -> FSM stays in ARM, first uart_tx_en only after busy falls.
REQ-032 start re-pulsed and sum changed to 5 during a message with sum=17 -> only 0x31,0x37(,0x0D,0x0A) sent, no second message.
REQ-033 reset_n low after second byte sent -> outputs at reset values immediately, no further strobes or done; new start then sends a full message.
REQ-034 start held high continuously with sum=12 -> back-to-back messages, each accepted in its done cycle, every byte 0x31,0x32(,0x0D,0x0A).
